alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage that feeds the combinational 64-bit ALU in each core.
- Captures decoded instructions tagged with a thread ID and resolves forwarding from EX/MEM and MEM/WB per thread.
- Detects load-use hazards and presents registered opcode plus forwarded A/B operands to the ALU.
- Uses a valid/ready handshake on both sides, with per-thread flush.

Parameters:
- XLEN, 64, datapath width.
- NTHREADS, 4, hardware threads per core.
- TID_W, 2, thread-ID width; equals log2(NTHREADS).
- RIDX_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  stage can accept
- in_tid  in  TID_W  thread ID
- in_aluop  in  4  ALU opcode
- in_rs1_idx, in_rs2_idx, in_rd_idx  in  RIDX_W each  register indices
- in_rs1_data, in_rs2_data  in  XLEN each  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_use_imm  in  1  B operand = imm
- in_is_load  in  1  instruction is a load (passed through)
- exm_valid, exm_wen, exm_is_load  in  1 each  EX/MEM producer status
- exm_tid  in  TID_W  EX/MEM thread ID
- exm_rd  in  RIDX_W  EX/MEM destination
- exm_data  in  XLEN  EX/MEM result
- mwb_valid, mwb_wen  in  1 each  MEM/WB producer status
- mwb_tid  in  TID_W  MEM/WB thread ID
- mwb_rd  in  RIDX_W  MEM/WB destination
- mwb_data  in  XLEN  MEM/WB result
- flush_valid  in  1  flush request
- flush_tid  in  TID_W  thread to flush
- alu_valid  out  1  ALU inputs valid
- alu_ready  in  1  EX/MEM accepts
- alu_a, alu_b  out  XLEN each  ALU operands
- alu_aluop  out  4  ALU opcode
- alu_tid  out  TID_W  thread ID
- alu_rd  out  RIDX_W  destination
- alu_is_load  out  1  load flag
- hazard  out  1  load-use stall active (debug)

Behaviour:
- Reset: when rst_n is low at a clk edge, the entry is cleared.
  - All outputs are 0; aluop = DUMMY (4'h0).
  - Reset mid-operation drops the held instruction.
- Storage is a single entry. in_ready = !held_valid || (alu_valid && alu_ready).
  - Capture occurs when in_valid && in_ready.
  - Latency is 1 cycle from capture to alu_valid; throughput is 1 instruction per cycle.
- x0 handling: a source index of 0 reads as 0 and is never forwarded. A producer with rd = 0 never forwards.
- Forwarding is combinational from the held entry, per source.
  - A source matches a producer only if producer valid && wen && same tid && rd == idx.
  - EX/MEM takes priority over MEM/WB; otherwise the stored operand is used.
  - Different-tid matches are ignored.
- Load-use hazard: an EX/MEM match with exm_is_load = 1 sets hazard = 1 and forces alu_valid = 0. The entry is held.
- Operand refresh while held (stalled or not accepted): on each clk, any source with a MEM/WB or non-load EX/MEM match writes its forwarded value back into the entry. This prevents loss when the producer retires.
- alu_valid = held_valid && !hazard.
- Output B selection:
  - Base value is the imm when in_use_imm = 1, else the forwarded rs2.
  - For SLL (4'h6) and SRL (4'h7), alu_b = {zeros, B[5:0]}, because the downstream ALU shifts by the full B.
- Flush: flush_valid with flush_tid == held tid clears held_valid on that edge.
  - Flush has priority over hold.
  - A same-cycle input with matching tid is not captured; in_ready still reflects the pre-flush state.
  - A non-matching tid is unaffected.
- Simultaneous accept-and-capture: an output transfer and a new capture on the same edge are permitted; the new entry replaces the old one.
- Opcodes other than 4'h0–4'h9 pass through unchanged.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants DUMMY/ADD/SUB/AND/OR/XOR/SLL/SRL/SLT/SLTU = 4'h0–4'h9.
  - XLEN, TID_W, RIDX_W.
  - Shift-amount width 6.
- Sub-module fwd_sel: one per source operand, instantiated twice.
  - Inputs: idx, tid, stored data, both producer buses.
  - Outputs: data, hit_exm, hit_mwb, load_hazard.

Test Plan:
- Reset: hold rst_n low for 2 clk with in_valid = 1, then release.
  - While low: alu_valid = 0, in_ready = 1, aluop = 0.
  - First capture appears one cycle after release.
- EX/MEM forwarding: ADD tid1 rs1 = 3 with stored 0x10 and exm tid1 rd3 = 0x55; mwb tid1 rd3 = 0x77.
  - Required: alu_a = 0x55.
  - With exm_tid = 2 instead: alu_a = 0x77.
- Load-use: exm_is_load = 1 matching rs2 for 2 cycles, then a mwb match with 0xABCD retires.
  - Required: alu_valid = 0 and hazard = 1 for 2 cycles.
  - Then alu_valid = 1 with alu_b = 0xABCD, even after mwb_valid drops.
- Shift masking: SLL with imm = 0x47, in_use_imm = 1.
  - Required: alu_b = 0x7.
- Backpressure and flush: alu_ready = 0 for 3 cycles.
  - Required: in_ready = 0 and outputs stable.
  - flush_tid matching the entry: alu_valid = 0 next cycle.
  - flush of another tid: entry retained.
- x0: rs1 = 0 with exm rd = 0 of matching tid carrying 0xFF.
  - Required: alu_a = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand stage: opcodes, widths and the
// layout of the single held ID/EX entry.
package alu_pkg;

  localparam int XLEN     = 64;
  localparam int NTHREADS = 4;
  localparam int TID_W    = 2;
  localparam int RIDX_W   = 5;
  localparam int SHAMT_W  = 6;

  localparam logic [3:0] ALU_DUMMY = 4'h0;
  localparam logic [3:0] ALU_ADD   = 4'h1;
  localparam logic [3:0] ALU_SUB   = 4'h2;
  localparam logic [3:0] ALU_AND   = 4'h3;
  localparam logic [3:0] ALU_OR    = 4'h4;
  localparam logic [3:0] ALU_XOR   = 4'h5;
  localparam logic [3:0] ALU_SLL   = 4'h6;
  localparam logic [3:0] ALU_SRL   = 4'h7;
  localparam logic [3:0] ALU_SLT   = 4'h8;
  localparam logic [3:0] ALU_SLTU  = 4'h9;

  typedef struct packed {
    logic              valid;
    logic [TID_W-1:0]  tid;
    logic [3:0]        aluop;
    logic [RIDX_W-1:0] rs1_idx;
    logic [RIDX_W-1:0] rs2_idx;
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic              use_imm;
    logic              is_load;
  } entry_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_sel.sv
// Per-source forwarding mux: picks EX/MEM, then MEM/WB, then the stored operand,
// with x0 reading as zero and never matching a producer.
module fwd_sel import alu_pkg::*; (
  input  logic [RIDX_W-1:0] idx_i,
  input  logic [TID_W-1:0]  tid_i,
  input  logic [XLEN-1:0]   stored_i,
  input  logic              exm_valid_i,
  input  logic              exm_wen_i,
  input  logic              exm_is_load_i,
  input  logic [TID_W-1:0]  exm_tid_i,
  input  logic [RIDX_W-1:0] exm_rd_i,
  input  logic [XLEN-1:0]   exm_data_i,
  input  logic              mwb_valid_i,
  input  logic              mwb_wen_i,
  input  logic [TID_W-1:0]  mwb_tid_i,
  input  logic [RIDX_W-1:0] mwb_rd_i,
  input  logic [XLEN-1:0]   mwb_data_i,
  output logic [XLEN-1:0]   data_o,
  output logic              hit_exm_o,
  output logic              hit_mwb_o,
  output logic              load_hazard_o
);

  logic idx_nz;

  // A nonzero source index also rules out any producer writing x0.
  assign idx_nz        = (idx_i != '0);
  assign hit_exm_o     = idx_nz && exm_valid_i && exm_wen_i &&
                         (exm_tid_i == tid_i) && (exm_rd_i == idx_i);
  assign hit_mwb_o     = idx_nz && mwb_valid_i && mwb_wen_i &&
                         (mwb_tid_i == tid_i) && (mwb_rd_i == idx_i);
  assign load_hazard_o = hit_exm_o && exm_is_load_i;

  always_comb begin
    data_o = stored_i;
    if (!idx_nz)        data_o = '0;
    else if (hit_exm_o) data_o = exm_data_i;
    else if (hit_mwb_o) data_o = mwb_data_i;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register and operand select for the 64-bit ALU: one held entry, per-thread
// forwarding and flush, load-use stall, and shift-amount masking of operand B.
module alu_operand_stage import alu_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TID_W-1:0]  in_tid,
  input  logic [3:0]        in_aluop,
  input  logic [RIDX_W-1:0] in_rs1_idx,
  input  logic [RIDX_W-1:0] in_rs2_idx,
  input  logic [RIDX_W-1:0] in_rd_idx,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic              in_is_load,
  input  logic              exm_valid,
  input  logic              exm_wen,
  input  logic              exm_is_load,
  input  logic [TID_W-1:0]  exm_tid,
  input  logic [RIDX_W-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              mwb_valid,
  input  logic              mwb_wen,
  input  logic [TID_W-1:0]  mwb_tid,
  input  logic [RIDX_W-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_data,
  input  logic              flush_valid,
  input  logic [TID_W-1:0]  flush_tid,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_aluop,
  output logic [TID_W-1:0]  alu_tid,
  output logic [RIDX_W-1:0] alu_rd,
  output logic              alu_is_load,
  output logic              hazard
);

  entry_t          entry_q, entry_d;
  logic [XLEN-1:0] fwd_a, fwd_b, b_base;
  logic            hit_exm_a, hit_mwb_a, lh_a;
  logic            hit_exm_b, hit_mwb_b, lh_b;
  logic            fire, flush_hit, in_flushed, capture;

  fwd_sel u_fwd_a (
    .idx_i(entry_q.rs1_idx), .tid_i(entry_q.tid), .stored_i(entry_q.rs1_data),
    .exm_valid_i(exm_valid), .exm_wen_i(exm_wen), .exm_is_load_i(exm_is_load),
    .exm_tid_i(exm_tid), .exm_rd_i(exm_rd), .exm_data_i(exm_data),
    .mwb_valid_i(mwb_valid), .mwb_wen_i(mwb_wen), .mwb_tid_i(mwb_tid),
    .mwb_rd_i(mwb_rd), .mwb_data_i(mwb_data),
    .data_o(fwd_a), .hit_exm_o(hit_exm_a), .hit_mwb_o(hit_mwb_a), .load_hazard_o(lh_a)
  );

  fwd_sel u_fwd_b (
    .idx_i(entry_q.rs2_idx), .tid_i(entry_q.tid), .stored_i(entry_q.rs2_data),
    .exm_valid_i(exm_valid), .exm_wen_i(exm_wen), .exm_is_load_i(exm_is_load),
    .exm_tid_i(exm_tid), .exm_rd_i(exm_rd), .exm_data_i(exm_data),
    .mwb_valid_i(mwb_valid), .mwb_wen_i(mwb_wen), .mwb_tid_i(mwb_tid),
    .mwb_rd_i(mwb_rd), .mwb_data_i(mwb_data),
    .data_o(fwd_b), .hit_exm_o(hit_exm_b), .hit_mwb_o(hit_mwb_b), .load_hazard_o(lh_b)
  );

  assign hazard     = entry_q.valid && (lh_a || lh_b);
  assign alu_valid  = entry_q.valid && !hazard;
  assign fire       = alu_valid && alu_ready;
  assign in_ready   = !entry_q.valid || fire;
  assign flush_hit  = flush_valid && entry_q.valid && (flush_tid == entry_q.tid);
  assign in_flushed = flush_valid && (flush_tid == in_tid);
  assign capture    = in_valid && in_ready && !in_flushed;

  always_comb begin
    entry_d = entry_q;
    if (capture) begin
      entry_d.valid    = 1'b1;
      entry_d.tid      = in_tid;
      entry_d.aluop    = in_aluop;
      entry_d.rs1_idx  = in_rs1_idx;
      entry_d.rs2_idx  = in_rs2_idx;
      entry_d.rd       = in_rd_idx;
      entry_d.rs1_data = in_rs1_data;
      entry_d.rs2_data = in_rs2_data;
      entry_d.imm      = in_imm;
      entry_d.use_imm  = in_use_imm;
      entry_d.is_load  = in_is_load;
    end else if (flush_hit || fire) begin
      entry_d.valid = 1'b0;
    end else if (entry_q.valid) begin
      // Absorb forwarded values so they survive the producer retiring; a pending
      // load result is not data yet and must not be written back.
      if (hit_exm_a && !exm_is_load) entry_d.rs1_data = exm_data;
      else if (hit_mwb_a)            entry_d.rs1_data = mwb_data;
      if (hit_exm_b && !exm_is_load) entry_d.rs2_data = exm_data;
      else if (hit_mwb_b)            entry_d.rs2_data = mwb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) entry_q <= '0;
    else        entry_q <= entry_d;
  end

  assign b_base      = entry_q.use_imm ? entry_q.imm : fwd_b;
  assign alu_a       = fwd_a;
  // The downstream shifter uses all of B, so clip it to a legal shift amount here.
  assign alu_b       = is_shift(entry_q.aluop) ?
                       {{(XLEN-SHAMT_W){1'b0}}, b_base[SHAMT_W-1:0]} : b_base;
  assign alu_aluop   = entry_q.aluop;
  assign alu_tid     = entry_q.tid;
  assign alu_rd      = entry_q.rd;
  assign alu_is_load = entry_q.is_load;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, forwarding, load-use stall, shift
// masking, backpressure, flush and x0 handling against hand-computed values.
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic              clk, rst_n;
  logic              in_valid, in_ready;
  logic [TID_W-1:0]  in_tid;
  logic [3:0]        in_aluop;
  logic [RIDX_W-1:0] in_rs1_idx, in_rs2_idx, in_rd_idx;
  logic [XLEN-1:0]   in_rs1_data, in_rs2_data, in_imm;
  logic              in_use_imm, in_is_load;
  logic              exm_valid, exm_wen, exm_is_load;
  logic [TID_W-1:0]  exm_tid;
  logic [RIDX_W-1:0] exm_rd;
  logic [XLEN-1:0]   exm_data;
  logic              mwb_valid, mwb_wen;
  logic [TID_W-1:0]  mwb_tid;
  logic [RIDX_W-1:0] mwb_rd;
  logic [XLEN-1:0]   mwb_data;
  logic              flush_valid;
  logic [TID_W-1:0]  flush_tid;
  logic              alu_valid, alu_ready;
  logic [XLEN-1:0]   alu_a, alu_b;
  logic [3:0]        alu_aluop;
  logic [TID_W-1:0]  alu_tid;
  logic [RIDX_W-1:0] alu_rd;
  logic              alu_is_load, hazard;

  int n_total = 0;
  int n_pass  = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_tid(in_tid), .in_aluop(in_aluop),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_is_load(in_is_load),
    .exm_valid(exm_valid), .exm_wen(exm_wen), .exm_is_load(exm_is_load),
    .exm_tid(exm_tid), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_valid(mwb_valid), .mwb_wen(mwb_wen), .mwb_tid(mwb_tid),
    .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .flush_valid(flush_valid), .flush_tid(flush_tid),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_aluop(alu_aluop), .alu_tid(alu_tid), .alu_rd(alu_rd),
    .alu_is_load(alu_is_load), .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_instr(input logic [1:0] tid, input logic [3:0] op,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                           input logic ui, input logic il);
    in_valid    = 1'b1;
    in_tid      = tid;
    in_aluop    = op;
    in_rs1_idx  = r1;
    in_rs2_idx  = r2;
    in_rd_idx   = rd;
    in_rs1_data = d1;
    in_rs2_data = d2;
    in_imm      = imm;
    in_use_imm  = ui;
    in_is_load  = il;
  endtask

  task automatic clr_prod();
    exm_valid = 1'b0; exm_wen = 1'b0; exm_is_load = 1'b0;
    exm_tid = '0; exm_rd = '0; exm_data = '0;
    mwb_valid = 1'b0; mwb_wen = 1'b0; mwb_tid = '0; mwb_rd = '0; mwb_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; alu_ready = 1'b1; flush_valid = 1'b0; flush_tid = '0;
    clr_prod();

    // Reset held for two edges while an instruction is offered
    set_instr(2'd0, ALU_ADD, 5'd1, 5'd2, 5'd3, 64'h5, 64'h6, 64'h0, 1'b0, 1'b0);
    tick();
    check("rst_valid0", alu_valid, 0);
    check("rst_ready0", in_ready, 1);
    check("rst_op0", alu_aluop, 0);
    tick();
    check("rst_valid1", alu_valid, 0);
    check("rst_ready1", in_ready, 1);
    check("rst_hazard", hazard, 0);
    rst_n = 1'b1; settle();
    check("post_rst_idle", alu_valid, 0);
    tick(); in_valid = 1'b0; settle();
    check("cap_valid", alu_valid, 1);
    check("cap_a", alu_a, 64'h5);
    check("cap_b", alu_b, 64'h6);
    check("cap_op", alu_aluop, ALU_ADD);

    // EX/MEM over MEM/WB, then tid mismatch handling (old entry fires on same edge)
    set_instr(2'd1, ALU_ADD, 5'd3, 5'd4, 5'd5, 64'h10, 64'h20, 64'h0, 1'b0, 1'b0);
    tick(); in_valid = 1'b0;
    exm_valid = 1'b1; exm_wen = 1'b1; exm_tid = 2'd1; exm_rd = 5'd3; exm_data = 64'h55;
    mwb_valid = 1'b1; mwb_wen = 1'b1; mwb_tid = 2'd1; mwb_rd = 5'd3; mwb_data = 64'h77;
    settle();
    check("exm_fwd_a", alu_a, 64'h55);
    check("exm_fwd_b", alu_b, 64'h20);
    check("exm_fwd_tid", alu_tid, 2'd1);
    check("exm_fwd_rd", alu_rd, 5'd5);
    exm_tid = 2'd2; settle();
    check("mwb_fwd_a", alu_a, 64'h77);
    mwb_tid = 2'd2; settle();
    check("other_tid_a", alu_a, 64'h10);
    clr_prod();
    tick(); settle();
    check("drain_empty", alu_valid, 0);

    // Load-use stall on rs2, resolved by MEM/WB, value retained after retire
    alu_ready = 1'b0;
    set_instr(2'd2, ALU_ADD, 5'd0, 5'd7, 5'd8, 64'h0, 64'h1111, 64'h0, 1'b0, 1'b1);
    tick(); in_valid = 1'b0;
    exm_valid = 1'b1; exm_wen = 1'b1; exm_is_load = 1'b1; exm_tid = 2'd2;
    exm_rd = 5'd7; exm_data = 64'hDEAD;
    settle();
    check("ld_hazard0", hazard, 1);
    check("ld_valid0", alu_valid, 0);
    check("ld_ready0", in_ready, 0);
    tick();
    check("ld_hazard1", hazard, 1);
    check("ld_valid1", alu_valid, 0);
    clr_prod();
    mwb_valid = 1'b1; mwb_wen = 1'b1; mwb_tid = 2'd2; mwb_rd = 5'd7; mwb_data = 64'hABCD;
    settle();
    check("ld_resolved_valid", alu_valid, 1);
    check("ld_resolved_haz", hazard, 0);
    check("ld_resolved_b", alu_b, 64'hABCD);
    check("ld_isload", alu_is_load, 1);
    tick(); mwb_valid = 1'b0; settle();
    check("ld_retired_b", alu_b, 64'hABCD);
    check("ld_retired_valid", alu_valid, 1);
    alu_ready = 1'b1;
    tick(); settle();
    check("ld_drain", alu_valid, 0);

    // Shift amount masking on immediate B
    set_instr(2'd0, ALU_SLL, 5'd1, 5'd2, 5'd9, 64'h3, 64'h99, 64'h47, 1'b1, 1'b0);
    tick();
    set_instr(2'd0, ALU_SRL, 5'd1, 5'd2, 5'd9, 64'h3, 64'h99, 64'hFFFF_FFFF_FFFF_FFC3, 1'b1, 1'b0);
    settle();
    check("sll_b", alu_b, 64'h7);
    check("sll_op", alu_aluop, ALU_SLL);
    tick();
    set_instr(2'd0, ALU_ADD, 5'd1, 5'd2, 5'd9, 64'h3, 64'h99, 64'h47, 1'b1, 1'b0);
    settle();
    check("srl_b", alu_b, 64'h3);
    tick(); in_valid = 1'b0; settle();
    check("add_imm_b", alu_b, 64'h47);
    tick();

    // Backpressure, flush of another tid, flush of the held tid
    alu_ready = 1'b0;
    set_instr(2'd3, ALU_XOR, 5'd9, 5'd10, 5'd11, 64'hAAAA, 64'hBBBB, 64'h0, 1'b0, 1'b0);
    tick();
    set_instr(2'd1, ALU_OR, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_ready", in_ready, 0);
      check("bp_a", alu_a, 64'hAAAA);
      check("bp_tid", alu_tid, 2'd3);
      tick();
    end
    in_valid = 1'b0;
    flush_valid = 1'b1; flush_tid = 2'd1;
    tick(); flush_valid = 1'b0; settle();
    check("flush_other_valid", alu_valid, 1);
    check("flush_other_op", alu_aluop, ALU_XOR);
    flush_valid = 1'b1; flush_tid = 2'd3;
    tick(); flush_valid = 1'b0; settle();
    check("flush_hit_valid", alu_valid, 0);
    check("flush_hit_ready", in_ready, 1);
    set_instr(2'd3, ALU_SUB, 5'd1, 5'd2, 5'd3, 64'h5, 64'h6, 64'h0, 1'b0, 1'b0);
    flush_valid = 1'b1; flush_tid = 2'd3;
    tick(); flush_valid = 1'b0; in_valid = 1'b0; settle();
    check("flush_blocks_cap", alu_valid, 0);
    set_instr(2'd3, ALU_SUB, 5'd1, 5'd2, 5'd3, 64'h5, 64'h6, 64'h0, 1'b0, 1'b0);
    tick(); in_valid = 1'b0; settle();
    check("post_flush_cap", alu_valid, 1);
    check("post_flush_op", alu_aluop, ALU_SUB);

    // Reset while an entry is held
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; settle();
    check("mid_rst_valid", alu_valid, 0);
    check("mid_rst_op", alu_aluop, 0);
    alu_ready = 1'b1;

    // x0 source and x0 producer, including a load producer to x0
    set_instr(2'd0, ALU_ADD, 5'd0, 5'd2, 5'd3, 64'h1234, 64'h6, 64'h0, 1'b0, 1'b0);
    exm_valid = 1'b1; exm_wen = 1'b1; exm_tid = 2'd0; exm_rd = 5'd0; exm_data = 64'hFF;
    tick(); in_valid = 1'b0; settle();
    check("x0_a", alu_a, 64'h0);
    check("x0_b", alu_b, 64'h6);
    exm_is_load = 1'b1; settle();
    check("x0_no_hazard", hazard, 0);
    check("x0_valid", alu_valid, 1);
    clr_prod();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
